// File: rtl/ad_rx_cal_pkg.sv
// Shared types and default constants for the AD936x RX IDELAY calibration block.
// Optional feature macro: AD_RX_CAL_PASSMAP_EN (adds the per-tap pass_map output).
package ad_rx_cal_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_EVAL   = 3'd4,
        ST_APPLY  = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    localparam int         DEF_TAP_W         = 5;
    localparam int         DEF_SETTLE_CYCLES = 16;
    localparam int         DEF_WINDOW_CYCLES = 256;
    localparam int         DEF_MIN_EYE       = 4;
    localparam logic [1:0] DEF_EXP_FRAME     = 2'b10;
    localparam int         DEF_DEFAULT_TAP   = 0;

endpackage

// File: rtl/ad_rx_cal_window_check.sv
// Per-tap timer: counts the settle period then the check window, and keeps a
// sticky flag for any frame mismatch seen inside the check window.
module ad_rx_cal_window_check #(
    parameter int SETTLE_CYCLES = 16,
    parameter int WINDOW_CYCLES = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic match,
    output logic settle_end,
    output logic window_end,
    output logic err
);

    localparam int TOTAL = SETTLE_CYCLES + WINDOW_CYCLES;
    localparam int CW    = $clog2(TOTAL + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] WIN_FIRST   = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0] WIN_LAST    = CW'(TOTAL - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          in_win;

    // Samples before WIN_FIRST belong to the settle period and are never judged.
    assign in_win     = (cnt_q >= WIN_FIRST);
    assign settle_end = en && (cnt_q == SETTLE_LAST);
    assign window_end = en && (cnt_q == WIN_LAST);
    assign err        = err_q;

    // Next-state: clear on tap load, otherwise advance while enabled and latch mismatches.
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (clr) begin
            cnt_d = '0;
            err_d = 1'b0;
        end else if (en) begin
            if (cnt_q != WIN_LAST) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (in_win && !match) begin
                err_d = 1'b1;
            end
        end
    end

    // Counter and sticky error registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

endmodule

// File: rtl/ad_rx_delay_cal.sv
// AD936x RX IDELAY calibration: sweeps every tap, judges the FRAME pattern at
// each one, then loads the centre of the first longest passing run.
// Optional feature macro: AD_RX_CAL_PASSMAP_EN adds output pass_map (one bit per tap).
module ad_rx_delay_cal
    import ad_rx_cal_pkg::*;
#(
    parameter int         TAP_W         = DEF_TAP_W,
    parameter int         SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int         WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int         MIN_EYE       = DEF_MIN_EYE,
    parameter logic [1:0] EXP_FRAME     = DEF_EXP_FRAME,
    parameter int         DEFAULT_TAP   = DEF_DEFAULT_TAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             frame_posedge,
    input  logic             frame_negedge,
    output logic             delay_ld,
    output logic [TAP_W-1:0] delay_tap,
    output logic             busy,
    output logic             done,
    output logic             locked,
    output logic             fail,
    output logic [TAP_W:0]   eye_len
`ifdef AD_RX_CAL_PASSMAP_EN
    ,
    output logic [2**TAP_W-1:0] pass_map
`endif
);

    localparam int LEN_W = TAP_W + 1;

    localparam logic [TAP_W-1:0] TAP_MAX   = '1;
    localparam logic [TAP_W-1:0] DEF_TAP_L = TAP_W'(DEFAULT_TAP);
    localparam logic [LEN_W-1:0] MIN_EYE_L = LEN_W'(MIN_EYE);

    state_e             state_q, state_d;
    logic [TAP_W-1:0]   tap_q, tap_d;
    logic [1:0]         frame_q;
    logic [LEN_W-1:0]   cur_len_q, cur_len_d;
    logic [TAP_W-1:0]   cur_start_q, cur_start_d;
    logic [LEN_W-1:0]   best_len_q, best_len_d;
    logic [TAP_W-1:0]   best_start_q, best_start_d;
    logic               delay_ld_q, delay_ld_d;
    logic [TAP_W-1:0]   delay_tap_q, delay_tap_d;
    logic               done_q, done_d;
    logic               locked_q, locked_d;
    logic               fail_q, fail_d;
    logic [LEN_W-1:0]   eye_len_q, eye_len_d;
    logic [LEN_W-1:0]   half_len;
`ifdef AD_RX_CAL_PASSMAP_EN
    logic [2**TAP_W-1:0] pass_map_q, pass_map_d;
`endif

    logic win_clr, win_en, win_match;
    logic settle_end, window_end, win_err;

    assign win_clr   = (state_q == ST_LOAD);
    assign win_en    = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
    assign win_match = (frame_q == EXP_FRAME);

    ad_rx_cal_window_check #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .WINDOW_CYCLES (WINDOW_CYCLES)
    ) u_win (
        .clk        (clk),
        .rst        (rst),
        .clr        (win_clr),
        .en         (win_en),
        .match      (win_match),
        .settle_end (settle_end),
        .window_end (window_end),
        .err        (win_err)
    );

    assign delay_ld  = delay_ld_q;
    assign delay_tap = delay_tap_q;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done      = done_q;
    assign locked    = locked_q;
    assign fail      = fail_q;
    assign eye_len   = eye_len_q;
`ifdef AD_RX_CAL_PASSMAP_EN
    assign pass_map  = pass_map_q;
`endif

    // Next-state and output logic; the load strobe is registered so it is high
    // exactly during the LOAD and APPLY states.
    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        cur_len_d    = cur_len_q;
        cur_start_d  = cur_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        delay_ld_d   = 1'b0;
        delay_tap_d  = delay_tap_q;
        done_d       = done_q;
        locked_d     = locked_q;
        fail_d       = fail_q;
        eye_len_d    = eye_len_q;
        half_len     = '0;
`ifdef AD_RX_CAL_PASSMAP_EN
        pass_map_d   = pass_map_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    tap_d        = '0;
                    cur_len_d    = '0;
                    cur_start_d  = '0;
                    best_len_d   = '0;
                    best_start_d = '0;
                    delay_ld_d   = 1'b1;
                    delay_tap_d  = '0;
                    done_d       = 1'b0;
                    locked_d     = 1'b0;
                    fail_d       = 1'b0;
                    eye_len_d    = '0;
`ifdef AD_RX_CAL_PASSMAP_EN
                    pass_map_d   = '0;
`endif
                end
            end
            ST_LOAD: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_end) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (window_end) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                // Strict '>' keeps the first of equally long runs.
                if (!win_err) begin
                    cur_len_d = cur_len_q + LEN_W'(1);
                    if (cur_len_q == '0) cur_start_d = tap_q;
                    if (cur_len_d > best_len_q) begin
                        best_len_d   = cur_len_d;
                        best_start_d = cur_start_d;
                    end
                end else begin
                    cur_len_d = '0;
                end
`ifdef AD_RX_CAL_PASSMAP_EN
                pass_map_d[tap_q] = !win_err;
`endif
                delay_ld_d = 1'b1;
                if (tap_q == TAP_MAX) begin
                    // Last tap: no wrap, so a run touching max never joins one at 0.
                    state_d  = ST_APPLY;
                    half_len = (best_len_d - LEN_W'(1)) >> 1;
                    if (best_len_d >= MIN_EYE_L) begin
                        delay_tap_d = best_start_d + half_len[TAP_W-1:0];
                    end else begin
                        delay_tap_d = DEF_TAP_L;
                    end
                end else begin
                    state_d     = ST_LOAD;
                    tap_d       = tap_q + TAP_W'(1);
                    delay_tap_d = tap_q + TAP_W'(1);
                end
            end
            ST_APPLY: begin
                // start is not looked at here, so a request on the DONE-entry edge is dropped.
                state_d   = ST_DONE;
                done_d    = 1'b1;
                locked_d  = (best_len_q >= MIN_EYE_L);
                fail_d    = (best_len_q <  MIN_EYE_L);
                eye_len_d = best_len_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, trackers, outputs and the single input capture register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tap_q        <= '0;
            frame_q      <= '0;
            cur_len_q    <= '0;
            cur_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
            delay_ld_q   <= 1'b0;
            delay_tap_q  <= '0;
            done_q       <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
            eye_len_q    <= '0;
`ifdef AD_RX_CAL_PASSMAP_EN
            pass_map_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            frame_q      <= {frame_posedge, frame_negedge};
            cur_len_q    <= cur_len_d;
            cur_start_q  <= cur_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
            delay_ld_q   <= delay_ld_d;
            delay_tap_q  <= delay_tap_d;
            done_q       <= done_d;
            locked_q     <= locked_d;
            fail_q       <= fail_d;
            eye_len_q    <= eye_len_d;
`ifdef AD_RX_CAL_PASSMAP_EN
            pass_map_q   <= pass_map_d;
`endif
        end
    end

endmodule

// File: tb/tb_ad_rx_delay_cal.sv
// Directed bench for ad_rx_delay_cal: an eye model drives FRAME from the last
// loaded tap; expected results are queued at start and checked at done.
module tb_ad_rx_delay_cal;

    localparam int TAP_W  = 5;
    localparam int NT     = 2**TAP_W;
    localparam int SETTLE = 16;
    localparam int WINDOW = 256;
    localparam int PER    = 2 + SETTLE + WINDOW;
    localparam int LAT    = NT * PER + 1;

    typedef struct {
        logic [TAP_W-1:0] tap;
        logic [TAP_W:0]   eye_len;
        logic             locked;
        logic             fail;
        int               lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             frame_posedge = 1'b0;
    logic             frame_negedge = 1'b1;
    logic             delay_ld;
    logic [TAP_W-1:0] delay_tap;
    logic             busy, done, locked, fail;
    logic [TAP_W:0]   eye_len;
`ifdef AD_RX_CAL_PASSMAP_EN
    logic [NT-1:0]    pass_map;
`endif

    ad_rx_delay_cal dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .frame_posedge (frame_posedge),
        .frame_negedge (frame_negedge),
        .delay_ld      (delay_ld),
        .delay_tap     (delay_tap),
        .busy          (busy),
        .done          (done),
        .locked        (locked),
        .fail          (fail),
        .eye_len       (eye_len)
`ifdef AD_RX_CAL_PASSMAP_EN
        ,
        .pass_map      (pass_map)
`endif
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;
    exp_t sb_q[$];

    logic [NT-1:0] tbl = '0;
    int glitch_tap = -1;
    int cur_tap = 0;
    int mcyc = 0;

    always @(posedge clk) cyc++;

    // Eye model: pattern is good only on passing taps; optional one-cycle glitch
    // timed so the registered copy lands on the last window cycle.
    always @(negedge clk) begin
        if (delay_ld) begin
            cur_tap = int'(delay_tap);
            mcyc = 0;
        end else begin
            mcyc++;
        end
        if (tbl[cur_tap] && !(cur_tap == glitch_tap && mcyc == SETTLE + WINDOW - 1))
            {frame_posedge, frame_negedge} = 2'b10;
        else if (tbl[cur_tap])
            {frame_posedge, frame_negedge} = 2'b11;
        else
            {frame_posedge, frame_negedge} = 2'b01;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NT-1:0] rng(input int lo, input int hi);
        logic [NT-1:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Reference: first longest run of passing taps, centre rounded down.
    function automatic exp_t model(input logic [NT-1:0] p);
        exp_t e;
        int bl = 0, bs = 0, cl = 0, cs = 0;
        for (int t = 0; t < NT; t++) begin
            if (p[t]) begin
                if (cl == 0) cs = t;
                cl++;
                if (cl > bl) begin
                    bl = cl;
                    bs = cs;
                end
            end else begin
                cl = 0;
            end
        end
        e.eye_len = (TAP_W+1)'(bl);
        e.locked  = (bl >= 4);
        e.fail    = (bl < 4);
        e.tap     = e.locked ? TAP_W'(bs + (bl - 1) / 2) : TAP_W'(0);
        e.lat     = LAT;
        return e;
    endfunction

    task automatic run_cal(input string name, input logic [NT-1:0] p, input int gtap,
                           input bit busy_start, input bit apply_start);
        exp_t e;
        logic [NT-1:0] eff;
        logic [TAP_W-1:0] lt;
        int t0, ldc;
        bit seen;
        eff = p;
        if (gtap >= 0) eff[gtap] = 1'b0;
        tbl = p;
        glitch_tap = gtap;
        sb_q.push_back(model(eff));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc;
        ldc = 0;
        lt = '0;
        seen = 1'b0;
        for (int k = 0; k < LAT + 200; k++) begin
            start = 1'b0;
            if (delay_ld) begin
                ldc++;
                lt = delay_tap;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy_start && k == 1000) start = 1'b1;
            if (apply_start && delay_ld && ldc == NT + 1) start = 1'b1;
            @(negedge clk);
        end
        e = sb_q.pop_front();
        check({name, "/done_seen"}, 32'(seen), 32'd1);
        check({name, "/tap"}, 32'(lt), 32'(e.tap));
        check({name, "/eye_len"}, 32'(eye_len), 32'(e.eye_len));
        check({name, "/locked"}, 32'(locked), 32'(e.locked));
        check({name, "/fail"}, 32'(fail), 32'(e.fail));
        check({name, "/latency"}, 32'(cyc - t0), 32'(e.lat));
        check({name, "/ld_count"}, 32'(ldc), 32'(NT + 1));
        check({name, "/busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({name, "/done_held"}, 32'(done), 32'd1);
        check({name, "/idle_after"}, 32'(busy), 32'd0);
        check({name, "/no_restart_ld"}, 32'(delay_ld), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "/delay_ld"}, 32'(delay_ld), 32'd0);
        check({name, "/delay_tap"}, 32'(delay_tap), 32'd0);
        check({name, "/busy"}, 32'(busy), 32'd0);
        check({name, "/done"}, 32'(done), 32'd0);
        check({name, "/locked"}, 32'(locked), 32'd0);
        check({name, "/fail"}, 32'(fail), 32'd0);
        check({name, "/eye_len"}, 32'(eye_len), 32'd0);
    endtask

    initial begin
        int nld;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("idle");

        run_cal("eye_10_19", rng(10, 19), -1, 1'b0, 1'b0);
        run_cal("two_runs", rng(3, 8) | rng(20, 25), -1, 1'b1, 1'b0);
        run_cal("all_pass", '1, -1, 1'b0, 1'b1);
        run_cal("all_fail", '0, -1, 1'b0, 1'b0);
        run_cal("glitch_12", rng(10, 19), 12, 1'b0, 1'b0);

        // Abort a sweep in the middle of tap 7's check window.
        tbl = rng(10, 19);
        glitch_tap = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7 * PER + 100) @(negedge clk);
        check("midsweep/busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nld = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (delay_ld) nld++;
        end
        check("abort/no_ld", 32'(nld), 32'd0);
        check("abort/idle", 32'(busy), 32'd0);
        run_cal("after_abort", rng(10, 19), -1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
